// File: rtl/mux_2to1.sv
// rtl/mux_2to1.sv - registered 2-to-1 multiplexer with asynchronous clear
// The output comes straight from y_q, so y never follows a glitch on a, b or sel.
module mux_2to1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] y_q;

    always_comb begin
        y_d = sel ? b : a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_mux_2to1.sv
// tb/tb_mux_2to1.sv - self-checking bench for mux_2to1 at WIDTH 1 and WIDTH 8
module tb_mux_2to1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, sel1 = 1'b0;
    logic       y1;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       sel8 = 1'b0;
    logic [7:0] y8;

    int tests = 0;
    int fails = 0;

    mux_2to1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .y(y1)
    );

    mux_2to1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .y(y8)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] exp8;
        #1;
        tests++;
        if (y1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_initial_y1: got %b expected 0", y1);
        end
        a1 = 1'b1; b1 = 1'b1; sel1 = 1'b1;
        a8 = 8'h11; b8 = 8'hEE; sel8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (y1 !== 1'b0 || y8 !== 8'h00) begin
                fails++;
                $display("FAIL reset_hold cycle %0d: got y1=%b y8=%h expected 0/00", i, y1, y8);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp8 = sel8 ? b8 : a8;
        @(posedge clk);
        #1;
        tests++;
        if (y1 !== 1'b1 || y8 !== exp8) begin
            fails++;
            $display("FAIL reset_release: got y1=%b y8=%h expected 1/%h", y1, y8, exp8);
        end
    endtask

    task automatic test_truth_table();
        logic [2:0] pat [8];
        logic       req [8];
        logic [2:0] p;
        pat[0] = 3'b000; pat[1] = 3'b010; pat[2] = 3'b100; pat[3] = 3'b110;
        pat[4] = 3'b001; pat[5] = 3'b011; pat[6] = 3'b101; pat[7] = 3'b111;
        req[0] = 1'b0; req[1] = 1'b0; req[2] = 1'b1; req[3] = 1'b1;
        req[4] = 1'b0; req[5] = 1'b1; req[6] = 1'b0; req[7] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            p = pat[i];
            a1 = p[2]; b1 = p[1]; sel1 = p[0];
            step();
            tests++;
            if (y1 !== req[i]) begin
                fails++;
                $display("FAIL truth_table abs=%b: got %b expected %b", p, y1, req[i]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; sel1 = 1'b0;
        @(posedge clk);
        #1;
        sel1 = 1'b1;
        @(negedge clk);
        tests++;
        if (y1 !== 1'b0) begin
            fails++;
            $display("FAIL latency_before: got %b expected 0", y1);
        end
        @(posedge clk);
        #1;
        tests++;
        if (y1 !== 1'b1) begin
            fails++;
            $display("FAIL latency_after: got %b expected 1", y1);
        end
    endtask

    task automatic test_toggle();
        logic prev_sel;
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel1 = i[0];
            prev_sel = sel1;
            step();
            tests++;
            if (y1 !== prev_sel) begin
                fails++;
                $display("FAIL toggle cycle %0d: got %b expected %b", i, y1, prev_sel);
            end
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b0;
        step();
        tests++;
        if (y8 !== 8'hA5) begin
            fails++;
            $display("FAIL wide_sel0: got %h expected a5", y8);
        end
        sel8 = 1'b1;
        step();
        tests++;
        if (y8 !== 8'h3C) begin
            fails++;
            $display("FAIL wide_sel1: got %h expected 3c", y8);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; sel8 = 1'b0;
        a1 = 1'b1; sel1 = 1'b0;
        step();
        tests++;
        if (y8 !== 8'hFF) begin
            fails++;
            $display("FAIL async_pre: got %h expected ff", y8);
        end
        #1 rst_n = 1'b0;
        a8 = 8'h5A;
        #1;
        tests++;
        if (y8 !== 8'h00 || y1 !== 1'b0) begin
            fails++;
            $display("FAIL async_clear: got y8=%h y1=%b expected 00/0", y8, y1);
        end
        #2 rst_n = 1'b1;
        #0.5;
        tests++;
        if (y8 !== 8'h00) begin
            fails++;
            $display("FAIL async_released_before_edge: got %h expected 00", y8);
        end
        @(posedge clk);
        #1;
        tests++;
        if (y8 !== 8'h5A || y1 !== 1'b1) begin
            fails++;
            $display("FAIL async_reload: got y8=%h y1=%b expected 5a/1", y8, y1);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp8;
        logic       exp1;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 1'($urandom);
            a1 = 1'($urandom); b1 = 1'($urandom); sel1 = 1'($urandom);
            exp8 = sel8 ? b8 : a8;
            exp1 = sel1 ? b1 : a1;
            step();
            tests++;
            if (y8 !== exp8 || y1 !== exp1) begin
                fails++;
                $display("FAIL random cycle %0d: got y8=%h y1=%b expected %h/%b", i, y8, y1, exp8, exp1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_toggle();
        test_wide();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
